// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fix.
// Ports: clk, rst (async, active-high), start, op[1:0], rs, rt (operands);
//        busy, done, hilo_we, hi, lo, unsupp (status and result).
// Build option: MDU_DIV_EN builds the divider; without it DIV/DIVU
//        complete in one cycle with unsupp=1 and no HI/LO write.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             unsupp
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH-1:0]   w_cap_b;
    logic [2*WIDTH-1:0] w_cap_acc;
    logic               w_cap_nq;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_acc_run;
    logic [2*WIDTH-1:0] w_fix;
    logic               w_unsupp;

`ifdef MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_r;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_rem_nxt;
    logic               w_cap_nr;
`else
    logic               r_unsupp;
`endif

    // op[0]=0 selects the signed variants
    assign w_rs_neg = ~op[0] & rs[WIDTH-1];
    assign w_rt_neg = ~op[0] & rt[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -rs : rs;
    assign w_rt_mag = w_rt_neg ? -rt : rt;

    // Multiplier sits in the low half of r_acc and shifts out as the
    // product shifts in from the top.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    // Dividend bits leave the top of r_acc's low half while quotient
    // bits enter at the bottom.
    assign w_shift   = {r_rem, r_acc[WIDTH-1]};
    assign w_diff    = w_shift - {2'b00, r_b};
    assign w_qbit    = ~w_diff[WIDTH+1];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    assign w_unsupp  = 1'b0;
`else
    assign w_unsupp  = r_unsupp;
`endif

    always_comb begin
        w_cap_b   = w_rs_mag;
        w_cap_acc = {{WIDTH{1'b0}}, w_rt_mag};
        w_cap_nq  = w_rs_neg ^ w_rt_neg;
`ifdef MDU_DIV_EN
        w_cap_nr  = 1'b0;
        if (op[1]) begin
            if (rt == '0) begin
                // zero divisor: raw bits through an unsigned divide
                // give quotient all ones and remainder = rs
                w_cap_b   = '0;
                w_cap_acc = {{WIDTH{1'b0}}, rs};
                w_cap_nq  = 1'b0;
            end else begin
                w_cap_b   = w_rt_mag;
                w_cap_acc = {{WIDTH{1'b0}}, w_rs_mag};
                w_cap_nr  = w_rs_neg;
            end
        end
`endif
    end

    always_comb begin
        w_acc_run = w_mul_nxt;
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            w_acc_run = {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], w_qbit};
        end
`endif
    end

    always_comb begin
        w_fix = r_neg_q ? -r_acc : r_acc;
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            w_fix[WIDTH-1:0] = r_neg_q ? -r_acc[WIDTH-1:0]
                                       : r_acc[WIDTH-1:0];
            w_fix[2*WIDTH-1:WIDTH] = r_neg_r ? -r_rem[WIDTH-1:0]
                                             : r_rem[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        hilo_we = 1'b0;
        unsupp  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    w_next = S_RUN;
`else
                    w_next = op[1] ? S_DONE : S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next  = S_IDLE;
                done    = 1'b1;
                hilo_we = ~w_unsupp;
                unsupp  = w_unsupp;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
`else
            r_unsupp <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= CNT_LAST;
                        r_b      <= w_cap_b;
                        r_acc    <= w_cap_acc;
                        r_neg_q  <= w_cap_nq;
`ifdef MDU_DIV_EN
                        r_is_div <= op[1];
                        r_neg_r  <= w_cap_nr;
                        r_rem    <= '0;
`else
                        r_unsupp <= op[1];
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= w_acc_run;
`ifdef MDU_DIV_EN
                    if (r_is_div) begin
                        r_rem <= w_rem_nxt;
                    end
`endif
                end
                S_FIX: begin
                    r_hi <= w_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_fix[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: random and directed stimulus for mdu_iter, checked every
// cycle against a latency/arithmetic reference model.
module tb_mdu_iter;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs;
    logic [W-1:0]  rt;
    logic          busy;
    logic          done;
    logic          hilo_we;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          unsupp;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .done   (done),
        .hilo_we(hilo_we),
        .hi     (hi),
        .lo     (lo),
        .unsupp (unsupp)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sp;
        longint sq;
        longint unsigned up;
        ref_result = '0;
        case (o)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                ref_result = 64'(sp);
            end
            2'd1: begin
                up = {32'b0, a} * {32'b0, b};
                ref_result = up;
            end
            2'd2: begin
                if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sp = longint'($signed(a)) % longint'($signed(b));
                    ref_result = {sp[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
                else ref_result = {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: cycles left in the current operation and the
    // HI/LO values that must be visible.
    int          m_left = 0;
    bit          m_uns  = 1'b0;
    logic [63:0] m_res  = '0;
    logic [31:0] e_hi   = '0;
    logic [31:0] e_lo   = '0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_left = 0;
            m_uns  = 1'b0;
            e_hi   = '0;
            e_lo   = '0;
        end else if (m_left == 0) begin
            if (start === 1'b1) begin
                m_res  = ref_result(op, rs, rt);
                m_uns  = !DIV_EN && op[1];
                m_left = m_uns ? 1 : W + 2;
            end
        end else begin
            m_left--;
        end
        if (m_left == 1 && !m_uns) begin
            e_hi = m_res[63:32];
            e_lo = m_res[31:0];
        end
        #1;
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("done", 64'(done), 64'(m_left == 1));
        chk("hilo_we", 64'(hilo_we), 64'(m_left == 1 && !m_uns));
        chk("unsupp", 64'(unsupp), 64'(m_left == 1 && m_uns));
        chk("hi", 64'(hi), 64'(e_hi));
        chk("lo", 64'(lo), 64'(e_lo));
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) chk({name, "_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic run(input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e);
        int c;
        bit uns;
        uns = !DIV_EN && o[1];
        issue(o, a, b);
        wait_done(name, c);
        chk({name, "_lat"}, 64'(c), uns ? 64'd0 : 64'(W + 1));
        if (!uns) begin
            chk({name, "_hi"}, 64'(hi), 64'(e[63:32]));
            chk({name, "_lo"}, 64'(lo), 64'(e[31:0]));
            chk({name, "_we"}, 64'(hilo_we), 64'd1);
        end
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        rs    = '0;
        rt    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // abort mid-run: async clear, no strobe later
        issue(2'd1, 32'd5, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we", 64'(hilo_we), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        run("mulu5x7", 2'd1, 32'd5, 32'd7, 64'd35);
        run("mult_m2x3", 2'd0, 32'hFFFF_FFFE, 32'd3,
            {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run("mulu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            {32'hFFFF_FFFE, 32'h0000_0001});
`ifdef MDU_DIV_EN
        run("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("divu_100_7", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        run("divu_by0", 2'd3, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF});
        run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'd0, 32'h8000_0000});
        run("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE,
            {32'd1, 32'hFFFF_FFFD});
`else
        run("mulu6x9", 2'd1, 32'd6, 32'd9, 64'd54);
        issue(2'd3, 32'd9, 32'd3);
        wait_done("unsup", c);
        chk("unsup_lat", 64'(c), 64'd0);
        chk("unsup_flag", 64'(unsupp), 64'd1);
        chk("unsup_we", 64'(hilo_we), 64'd0);
        chk("unsup_hi", 64'(hi), 64'd0);
        chk("unsup_lo", 64'(lo), 64'd54);
`endif

        // starts while busy are ignored; next start lands right after DONE
        issue(2'd1, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; rs = 32'd77; rt = 32'd88;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; op = 2'd1; rs = 32'd11; rt = 32'd13;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", c);
        chk("ign_lat", 64'(c), 64'(W - 19));
        chk("ign_lo", 64'(lo), 64'd3000);
        chk("ign_hi", 64'(hi), 64'd0);
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs = 32'd2; rt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 64'(busy), 64'd1);
        wait_done("restart", c);
        chk("restart_lo", 64'(lo), 64'd6);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            int          k;
            bit          uns;
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            uns = !DIV_EN && o[1];
            issue(o, a, b);
            if (!uns && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 20);
                repeat (k) @(negedge clk);
                start = 1'b1; rs = $urandom; rt = $urandom;
                @(negedge clk);
                start = 1'b0;
                wait_done("rnd", c);
                chk("rnd_lat_pulse", 64'(c), 64'(W - k));
            end else begin
                wait_done("rnd", c);
                chk("rnd_lat", 64'(c), uns ? 64'd0 : 64'(W + 1));
            end
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
